audio_rate_fifo: RTL and testbench

//  Elastic audio buffer between asynchronous-rate sample sources (sound chips, DAC taps)
//  and the HDMI transmitter's audio path. Accepts stereo samples on an input strobe,

---
 rtl/audio_rate_fifo.sv | 132 +++++++++++++
 tb/tb_audio_rate_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_rate_fifo.sv
// Elastic stereo audio FIFO with a phase-accumulated SAMPLERATE output strobe.
// Optional: `define AUDIO_FIFO_ZERO_ON_UNDERRUN_EN to mute on starvation instead of holding the last sample.
module audio_rate_fifo #(
    parameter int unsigned SAMPLERATE = 192000,
    parameter int unsigned CLKRATE    = 28000000,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [15:0]    in_l,
    input  logic signed [15:0]    in_r,
    input  logic                  in_stb,
    output logic signed [15:0]    out_l,
    output logic signed [15:0]    out_r,
    output logic                  out_stb,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underrun,
    output logic                  overrun
);

    localparam int unsigned        DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_HALF = (DEPTH_LOG2 + 1)'(DEPTH / 2);

    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic [31:0] acc_q, acc_d;
    logic [32:0] acc_sum;
    logic        tick;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;

    logic        full, empty;
    logic        pop, push_ok, load_empty, underrun_d;
    logic [15:0] empty_l, empty_r;

    // Rate generator: remainder carried in acc, so the long-run average is exact.
    always_comb begin
        acc_sum = {1'b0, acc_q} + 33'(SAMPLERATE);
        tick    = (acc_sum >= 33'(CLKRATE));
        acc_d   = tick ? 32'(acc_sum - 33'(CLKRATE)) : acc_sum[31:0];
    end

`ifdef AUDIO_FIFO_ZERO_ON_UNDERRUN_EN
    assign empty_l = '0;
    assign empty_r = '0;
`else
    assign empty_l = out_l;
    assign empty_r = out_r;
`endif

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        load_empty = 1'b0;
        underrun_d = 1'b0;
        unique case (state_q)
            ST_PRIME: begin
                if (tick) load_empty = 1'b1;
                if (level >= LVL_HALF) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tick) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        load_empty = 1'b1;
                        underrun_d = 1'b1;
                        state_d    = ST_PRIME;
                    end
                end
            end
            default: state_d = ST_PRIME;
        endcase
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        push_ok = in_stb && (!full || pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            state_q  <= ST_PRIME;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            out_l    <= '0;
            out_r    <= '0;
            out_stb  <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            state_q  <= state_d;
            out_stb  <= tick;
            underrun <= underrun_d;
            overrun  <= in_stb && !push_ok;

            if (pop) begin
                {out_l, out_r} <= mem[rd_ptr];
                rd_ptr         <= rd_ptr + 1'b1;
            end else if (load_empty) begin
                out_l <= empty_l;
                out_r <= empty_r;
            end

            if (push_ok) wr_ptr <= wr_ptr + 1'b1;

            unique case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is not reset; level and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {in_l, in_r};
    end

endmodule

// File: tb/tb_audio_rate_fifo.sv
// Randomised and directed bench for audio_rate_fifo against a queue-based reference model.
module tb_audio_rate_fifo;

    localparam int SR    = 192000;
    localparam int CR    = 28000000;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        in_stb = 1'b0;
    logic [15:0] in_l   = '0;
    logic [15:0] in_r   = '0;
    logic [15:0] out_l, out_r;
    logic        out_stb, underrun, overrun;
    logic [DL:0] level;

    audio_rate_fifo #(
        .SAMPLERATE (SR),
        .CLKRATE    (CR),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_l     (in_l),
        .in_r     (in_r),
        .in_stb   (in_stb),
        .out_l    (out_l),
        .out_r    (out_r),
        .out_stb  (out_stb),
        .level    (level),
        .underrun (underrun),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: sample queue plus arithmetic phase accumulator.
    longint      m_acc;
    logic [31:0] m_q[$];
    bit          m_run;
    logic [15:0] m_l, m_r;
    bit          m_stb, m_under, m_over;

    int cyc, last_stb, min_gap, max_gap, stb_cnt, under_cnt, over_cnt;

    function automatic logic [15:0] starve_value(input logic [15:0] prev);
`ifdef AUDIO_FIFO_ZERO_ON_UNDERRUN_EN
        return 16'h0000;
`else
        return prev;
`endif
    endfunction

    task automatic model_step(input bit rst, input bit s, input logic [15:0] l, input logic [15:0] r);
        int occ;
        bit tick;
        bit run_next;
        if (rst) begin
            m_acc = 0; m_q.delete(); m_run = 0;
            m_l = '0; m_r = '0; m_stb = 0; m_under = 0; m_over = 0;
            return;
        end
        tick     = (m_acc + SR >= CR);
        m_acc    = tick ? m_acc + SR - CR : m_acc + SR;
        occ      = m_q.size();
        run_next = m_run;
        m_stb    = tick;
        m_under  = 0;
        m_over   = 0;
        if (!m_run) begin
            if (tick) begin m_l = starve_value(m_l); m_r = starve_value(m_r); end
            if (occ >= DEPTH / 2) run_next = 1;
        end else if (tick) begin
            if (occ > 0) begin
                {m_l, m_r} = m_q.pop_front();
            end else begin
                m_l = starve_value(m_l); m_r = starve_value(m_r);
                m_under = 1; run_next = 0;
            end
        end
        if (s) begin
            if (m_q.size() < DEPTH) m_q.push_back({l, r});
            else m_over = 1;
        end
        m_run = run_next;
    endtask

    task automatic clear_stats();
        stb_cnt = 0; under_cnt = 0; over_cnt = 0;
        min_gap = 1 << 30; max_gap = 0; last_stb = -1;
    endtask

    task automatic step(input bit rst, input bit s, input logic [15:0] l, input logic [15:0] r);
        int gap;
        reset = rst; in_stb = s; in_l = l; in_r = r;
        @(posedge clk);
        model_step(rst, s, l, r);
        #1;
        check("out_stb", out_stb, m_stb);
        check("out_l", out_l, m_l);
        check("out_r", out_r, m_r);
        check("underrun", underrun, m_under);
        check("overrun", overrun, m_over);
        check("level", level, m_q.size());
        cyc++;
        if (rst) begin
            last_stb = -1;
        end else if (out_stb) begin
            stb_cnt++;
            if (last_stb >= 0) begin
                gap = cyc - last_stb;
                if (gap < min_gap) min_gap = gap;
                if (gap > max_gap) max_gap = gap;
            end
            last_stb = cyc;
        end
        if (underrun) under_cnt++;
        if (overrun) over_cnt++;
    endtask

    logic [15:0] seen_l[$];
    bit          seen_u[$];

    initial begin
        int n, lmin, lmax, p5_under, p5_over;
        bit primed;
        logic [15:0] hold_exp;
        int rates[4];
        cyc = 0;
        clear_stats();

        // Reset state, then idle: exactly 6 strobes per 875 cycles.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_level", level, 0);
        check("rst_out_l", out_l, 0);
        check("rst_out_r", out_r, 0);
        check("rst_stb", out_stb, 0);
        check("rst_flags", {underrun, overrun}, 0);
        clear_stats();
        for (int i = 0; i < 8750; i++) step(0, 0, 0, 0);
        check("p1_strobes", stb_cnt, 60);
        check("p1_gap_min", min_gap, 145);
        check("p1_gap_max", max_gap, 146);
        check("p1_underruns", under_cnt, 0);
        check("p1_out_l", out_l, 0);

        // Prime with 1..8, drain, then one underrun.
        for (int i = 1; i <= 8; i++) step(0, 1, 16'(i), 16'(i) ^ 16'hFFFF);
        check("p2_level", level, 8);
        seen_l.delete(); seen_u.delete();
        n = 0;
        while (seen_l.size() < 9 && n < 2000) begin
            step(0, 0, 0, 0);
            n++;
            if (out_stb) begin seen_l.push_back(out_l); seen_u.push_back(underrun); end
        end
        check("p2_strobes", seen_l.size(), 9);
`ifdef AUDIO_FIFO_ZERO_ON_UNDERRUN_EN
        hold_exp = 16'h0000;
`else
        hold_exp = 16'h0008;
`endif
        if (seen_l.size() == 9) begin
            for (int i = 0; i < 8; i++) begin
                check("p2_sample", seen_l[i], i + 1);
                check("p2_no_under", seen_u[i], 0);
            end
            check("p2_under", seen_u[8], 1);
            check("p2_hold", seen_l[8], hold_exp);
        end

        // 17 back-to-back pushes into an empty FIFO before any tick.
        step(1, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            step(0, 1, 16'(100 + i), 16'(200 + i));
            if (i == 16) check("p3_no_over16", overrun, 0);
        end
        check("p3_over17", overrun, 1);
        check("p3_level", level, 16);
        step(0, 0, 0, 0);
        check("p3_over_pulse", overrun, 0);

        // Push coincident with a tick while full.
        n = 0;
        while (m_acc + SR < CR && n < 400) begin step(0, 0, 0, 0); n++; end
        check("p4_tick_found", (m_acc + SR >= CR), 1);
        step(0, 1, 16'h7777, 16'h7777);
        check("p4_stb", out_stb, 1);
        check("p4_level", level, 16);
        check("p4_over", overrun, 0);
        check("p4_pop", out_l, 101);
        seen_l.delete();
        n = 0;
        clear_stats();
        while (seen_l.size() < 16 && n < 3000) begin
            step(0, 0, 0, 0);
            n++;
            if (out_stb) seen_l.push_back(out_l);
        end
        check("p4_strobes", seen_l.size(), 16);
        if (seen_l.size() == 16) begin
            for (int i = 0; i < 15; i++) check("p4_sample", seen_l[i], 102 + i);
            check("p4_last", seen_l[15], 16'h7777);
        end
        check("p4_underruns", under_cnt, 0);

        // Source slightly slower than sink: level stays near half after priming.
        step(1, 0, 0, 0);
        lmin = 99; lmax = -1; p5_under = 0; p5_over = 0; primed = 0;
        for (int i = 0; i < 20000; i++) begin
            step(0, (i % 146) == 0, 16'($urandom) | 16'h0001, 16'($urandom));
            if (primed) begin
                if (int'(level) < lmin) lmin = int'(level);
                if (int'(level) > lmax) lmax = int'(level);
                if (underrun) p5_under++;
                if (overrun) p5_over++;
            end
            if (m_run) primed = 1;
        end
        check("p5_primed", primed, 1);
        check("p5_lvl_min", lmin >= 6, 1);
        check("p5_lvl_max", lmax <= 10, 1);
        check("p5_underruns", p5_under, 0);
        check("p5_overruns", p5_over, 0);

        // Reset mid-stream at level 5.
        n = 0;
        while (level != 5 && n < 3000) begin step(0, 0, 0, 0); n++; end
        check("p6_level5", level, 5);
        check("p6_out_nz", out_l != 0, 1);
        step(1, 0, 0, 0);
        check("p6_level", level, 0);
        check("p6_out_l", out_l, 0);
        check("p6_stb", out_stb, 0);
        n = 0;
        while (!out_stb && n < 400) begin step(0, 0, 0, 0); n++; end
        check("p6_first_stb", n, 146);

        // Random traffic at several push rates with occasional resets.
        rates = '{40, 146, 300, 146};
        step(1, 0, 0, 0);
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 5000; i++) begin
                step($urandom_range(3999) == 0, $urandom_range(rates[seg] - 1) == 0,
                     16'($urandom), 16'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
